// File: rtl/display_scan_7seg_pkg.sv
// Shared definitions for the multiplexed M.SS display: state encodings,
// segment constants and the BCD digit pattern table.
package display_scan_7seg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } disp_state_t;

   // Active-low segments ordered {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   function automatic logic [6:0] seg_pattern(input logic [3:0] bcd);
      case (bcd)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return SEG_DASH;
      endcase
   endfunction

endpackage

// File: rtl/display_scan_7seg_bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes show a dash.
module bcd_to_7seg
   import display_scan_7seg_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   assign seg = seg_pattern(bcd);

endmodule

// File: rtl/display_scan_7seg.sv
// Three-digit common-anode scan driver for the microwave timer (M.SS), with
// steady, paused-blink and done-blink display modes.
//
// state | meaning
// IDLE  | steady display, waiting for the magnetron to start
// RUN   | steady display while counting down
// PAUSE | door/stop pause, all digits blink
// DONE  | countdown finished, "0.00" blinks, buzzer enabled
module display_scan_7seg
   import display_scan_7seg_pkg::*;
#(
   parameter int SCAN_DIV      = 50000,
   parameter int BLINK_TICKS   = 250,
   parameter int DONE_BLINKS   = 3,
   parameter int LEADING_BLANK = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] count_us,
   input  logic [3:0] count_ds,
   input  logic [3:0] count_m,
   input  logic       running,
   input  logic       zero,
   output logic [6:0] seg,
   output logic       dp,
   output logic [2:0] an,
   output logic       done
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam int HW = $clog2(2 * DONE_BLINKS + 1);

   logic [PW-1:0] presc;
   logic          tick;
   logic [1:0]    slot;
   logic [3:0]    snap_us, snap_ds, snap_m;
   disp_state_t   state, state_nx;
   logic [BW-1:0] blink_cnt;
   logic [HW-1:0] half_cnt;
   logic          phase_on;
   logic          blink_wrap;
   logic [3:0]    digit;
   logic [6:0]    seg_dec;
   logic          blank_digit;

   assign tick       = (presc == PW'(SCAN_DIV - 1));
   assign blink_wrap = tick && (blink_cnt == BW'(BLINK_TICKS - 1));
   assign done       = (state == ST_DONE);

   always_ff @(posedge clock) begin
      if (reset) begin
         presc   <= '0;
         slot    <= 2'd0;
         snap_us <= 4'd0;
         snap_ds <= 4'd0;
         snap_m  <= 4'd0;
      end else begin
         presc <= tick ? '0 : presc + PW'(1);
         if (tick) begin
            slot <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
            // Capture once per frame so a frame never mixes old and new digits
            if (slot == 2'd2) begin
               snap_us <= count_us;
               snap_ds <= count_ds;
               snap_m  <= count_m;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (running) state_nx = ST_RUN;
         ST_RUN: begin
            if (zero)          state_nx = ST_DONE;
            else if (!running) state_nx = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (running)   state_nx = ST_RUN;
            else if (zero) state_nx = ST_IDLE;
         end
         ST_DONE: begin
            if (running) state_nx = ST_RUN;
            else if (blink_wrap && half_cnt == HW'(2 * DONE_BLINKS - 1))
               state_nx = ST_IDLE;
         end
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Blinking modes start in the OFF phase so the mode change is visible at once
   always_ff @(posedge clock) begin
      if (reset) begin
         blink_cnt <= '0;
         half_cnt  <= '0;
         phase_on  <= 1'b1;
      end else if (state_nx != state &&
                   (state_nx == ST_PAUSE || state_nx == ST_DONE)) begin
         blink_cnt <= '0;
         half_cnt  <= '0;
         phase_on  <= 1'b0;
      end else if (state_nx == ST_IDLE || state_nx == ST_RUN) begin
         blink_cnt <= '0;
         half_cnt  <= '0;
         phase_on  <= 1'b1;
      end else if (tick) begin
         if (blink_wrap) begin
            blink_cnt <= '0;
            half_cnt  <= half_cnt + HW'(1);
            phase_on  <= ~phase_on;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end
   end

   always_comb begin
      case (slot)
         2'd0:    digit = snap_us;
         2'd1:    digit = snap_ds;
         default: digit = snap_m;
      endcase
   end

   assign blank_digit = !phase_on ||
                        ((LEADING_BLANK != 0) && slot == 2'd2 &&
                         snap_m == 4'd0 && state != ST_DONE);

   bcd_to_7seg u_dec (
      .bcd (digit),
      .seg (seg_dec)
   );

   // One dead clock per slot change keeps the previous digit from ghosting
   always_ff @(posedge clock) begin
      if (reset || tick) begin
         seg <= SEG_BLANK;
         dp  <= 1'b1;
         an  <= 3'b111;
      end else begin
         an  <= ~(3'b001 << slot);
         seg <= blank_digit ? SEG_BLANK : seg_dec;
         dp  <= !(slot == 2'd2 && !blank_digit);
      end
   end

endmodule

// File: tb/tb_display_scan_7seg.sv
// Directed bench for display_scan_7seg with a short scan divider and blink timing.
module tb_display_scan_7seg;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] count_us, count_ds, count_m;
   logic       running, zero;
   logic [6:0] seg;
   logic       dp;
   logic [2:0] an;
   logic       done;

   int n_tests = 0;
   int n_fail  = 0;
   int dead, bad_an, bad_dp, n, guard, dcnt;
   logic flag, saw_min, saw_blank;

   display_scan_7seg #(
      .SCAN_DIV(4), .BLINK_TICKS(3), .DONE_BLINKS(2), .LEADING_BLANK(1)
   ) dut (
      .clock(clock), .reset(reset), .count_us(count_us), .count_ds(count_ds),
      .count_m(count_m), .running(running), .zero(zero), .seg(seg), .dp(dp),
      .an(an), .done(done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_an(input string tag, input logic [2:0] want);
      int i = 0;
      while (an !== want && i < 64) begin
         @(negedge clock);
         i++;
      end
      chk(tag, {29'd0, an}, {29'd0, want});
   endtask

   task automatic show(input string tag, input logic [2:0] want,
                       input logic [6:0] seg_exp, input logic dp_exp);
      wait_an({tag, "_gap"}, 3'b111);
      wait_an({tag, "_an"}, want);
      chk({tag, "_seg"}, {25'd0, seg}, {25'd0, seg_exp});
      chk({tag, "_dp"}, {31'd0, dp}, {31'd0, dp_exp});
   endtask

   task automatic set_count(input logic [3:0] m, input logic [3:0] ds, input logic [3:0] us);
      count_m = m; count_ds = ds; count_us = us;
   endtask

   initial begin
      set_count(4'd1, 4'd2, 4'd5);
      running = 1'b0;
      zero    = 1'b0;

      // 1: reset, then first slot and one full frame
      repeat (3) @(negedge clock);
      chk("rst_seg", {25'd0, seg}, 32'h7F);
      chk("rst_an", {29'd0, an}, 32'h7);
      chk("rst_dp", {31'd0, dp}, 32'h1);
      chk("rst_done", {31'd0, done}, 32'h0);
      reset = 1'b0;
      @(negedge clock);
      chk("first_an", {29'd0, an}, 32'h6);
      chk("first_seg", {25'd0, seg}, 32'h40);
      repeat (14) @(negedge clock);
      show("t1_us", 3'b110, 7'h12, 1'b1);
      show("t1_ds", 3'b101, 7'h24, 1'b1);
      show("t1_m", 3'b011, 7'h79, 1'b0);

      // 2: leading blank on minute
      set_count(4'd0, 4'd3, 4'd0);
      repeat (16) @(negedge clock);
      show("t2_m", 3'b011, 7'h7F, 1'b1);
      show("t2_ds", 3'b101, 7'h30, 1'b1);
      show("t2_us", 3'b110, 7'h40, 1'b1);

      // 3: frame coherence, dead time, dp placement
      set_count(4'd1, 4'd2, 4'd5);
      repeat (16) @(negedge clock);
      show("t3_old", 3'b110, 7'h12, 1'b1);
      count_us = 4'd6;
      @(negedge clock);
      chk("t3_hold", {25'd0, seg}, 32'h12);
      show("t3_new", 3'b110, 7'h02, 1'b1);
      dead = 0; bad_an = 0; bad_dp = 0;
      repeat (24) begin
         @(negedge clock);
         if (an == 3'b111) dead++;
         else if (an != 3'b110 && an != 3'b101 && an != 3'b011) bad_an++;
         if (dp == 1'b0 && an != 3'b011) bad_dp++;
      end
      chk("t3_dead", dead, 6);
      chk("t3_onehot", bad_an, 0);
      chk("t3_dp_pos", bad_dp, 0);

      // 4: pause blink, then resume
      running = 1'b1;
      repeat (3) @(negedge clock);
      chk("t4_run_done", {31'd0, done}, 32'h0);
      running = 1'b0;
      @(negedge clock);
      flag = 1'b1;
      repeat (7) begin
         @(negedge clock);
         if (an != 3'b111 && seg != 7'h7F) flag = 1'b0;
      end
      chk("t4_off", {31'd0, flag}, 32'h1);
      guard = 0;
      while (!(an != 3'b111 && seg != 7'h7F) && guard < 30) begin
         @(negedge clock);
         guard++;
      end
      chk("t4_on_seen", {31'd0, (an != 3'b111 && seg != 7'h7F)}, 32'h1);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!(an != 3'b111 && seg == 7'h7F) && n < 30);
      chk("t4_on_len", n, 12);
      running = 1'b1;
      @(negedge clock);
      flag = 1'b1;
      repeat (12) begin
         @(negedge clock);
         if (an != 3'b111 && seg == 7'h7F) flag = 1'b0;
      end
      chk("t4_steady", {31'd0, flag}, 32'h1);

      // 5: countdown reaches zero, DONE blinks then returns to IDLE
      set_count(4'd0, 4'd0, 4'd0);
      repeat (16) @(negedge clock);
      running = 1'b0;
      zero    = 1'b1;
      @(negedge clock);
      chk("t5_done_rise", {31'd0, done}, 32'h1);
      dcnt = 0; saw_min = 1'b0; saw_blank = 1'b0;
      while (done && dcnt < 80) begin
         dcnt++;
         if (an == 3'b011 && seg == 7'h40 && dp == 1'b0) saw_min = 1'b1;
         if (an != 3'b111 && seg == 7'h7F) saw_blank = 1'b1;
         @(negedge clock);
      end
      chk("t5_done_len", {31'd0, (dcnt >= 45 && dcnt <= 48)}, 32'h1);
      chk("t5_min_zero", {31'd0, saw_min}, 32'h1);
      chk("t5_blinked", {31'd0, saw_blank}, 32'h1);
      zero = 1'b0;
      show("t5_m", 3'b011, 7'h7F, 1'b1);
      show("t5_us", 3'b110, 7'h40, 1'b1);

      // 6: dash for invalid BCD, reset inside DONE
      set_count(4'd1, 4'd2, 4'hB);
      repeat (16) @(negedge clock);
      show("t6_dash", 3'b110, 7'h3F, 1'b1);
      running = 1'b1;
      zero    = 1'b1;
      @(negedge clock);
      chk("t6_run_first", {31'd0, done}, 32'h0);
      running = 1'b0;
      @(negedge clock);
      chk("t6_done", {31'd0, done}, 32'h1);
      repeat (5) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("t6_rst_done", {31'd0, done}, 32'h0);
      chk("t6_rst_an", {29'd0, an}, 32'h7);
      chk("t6_rst_seg", {25'd0, seg}, 32'h7F);
      chk("t6_rst_dp", {31'd0, dp}, 32'h1);
      reset = 1'b0;
      zero  = 1'b0;
      @(negedge clock);
      chk("t6_post_an", {29'd0, an}, 32'h6);
      chk("t6_post_seg", {25'd0, seg}, 32'h40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
